stream_narrow_to_wide_mem: RTL
==============================

# stream_narrow_to_wide_mem

Adapter that lets one narrow memory initiator access a wide, word-organised memory port. It places each narrow request into the correct lane of a wide word and returns the matching narrow slice of the wide response. It sits in front of the wide bank-side interface of the memory island, where narrow cores share wide SRAM words. It is the counterpart of the wide-to-banks splitter: that block splits one wide access over many narrow banks, and this block merges a narrow access into one wide word.

## Interface
- AddrWidth, 32, byte address width.
- NarrowDataWidth, 32, initiator data width; power of two, ≥8.
- WideDataWidth, 128, memory data width; power of two; integer multiple of NarrowDataWidth.
- WUserWidth, 1, request sideband width.
- RUserWidth, 1, response sideband width.
- MaxTrans, 4, maximum outstanding transactions; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  narrow request valid.
- gnt_o  out  1  narrow request granted.
- addr_i  in  AddrWidth  byte address.
- wdata_i  in  NarrowDataWidth  write data.
- strb_i  in  NarrowDataWidth/8  write strobe.
- wuser_i  in  WUserWidth  request sideband.
- we_i  in  1  write enable.
- rvalid_o  out  1  narrow response valid; issued for both reads and writes.
- rready_i  in  1  narrow response ready.
- rdata_o  out  NarrowDataWidth  response data.
- ruser_o  out  RUserWidth  response sideband.
- mem_req_o  out  1  wide request valid.
- mem_gnt_i  in  1  wide request granted.
- mem_addr_o  out  AddrWidth  wide-aligned byte address.
- mem_wdata_o  out  WideDataWidth  write data.
- mem_strb_o  out  WideDataWidth/8  write strobe.
- mem_wuser_o  out  WUserWidth  request sideband.
- mem_we_o  out  1  write enable.
- mem_rvalid_i  in  1  wide response valid; has no ready, so the block must always accept it.
- mem_rdata_i  in  WideDataWidth  response data.
- mem_ruser_i  in  RUserWidth  response sideband.

## Operation
- Definitions:
  - NB = NarrowDataWidth/8.
  - WB = WideDataWidth/8.
  - Lanes = WB/NB.
  - lane = addr_i[$clog2(WB)-1:$clog2(NB)]. Address bits below $clog2(NB) are ignored.
- Request path is combinational:
  - mem_addr_o = addr_i with the low $clog2(WB) bits cleared.
  - mem_wdata_o = wdata_i replicated Lanes times.
  - mem_strb_o = strb_i shifted to lane×NB; all other strobe bits are 0.
  - mem_we_o = we_i.
  - mem_wuser_o = wuser_i.
- Credit:
  - credit_ok = (outstanding < MaxTrans).
  - mem_req_o = req_i & credit_ok.
  - gnt_o = mem_gnt_i & credit_ok.
  - A request is accepted when req_i & gnt_o.
- Lane FIFO:
  - Depth MaxTrans, width $clog2(Lanes), minimum 1 bit.
  - Pushes lane on accept; pops on rvalid_o & rready_i.
- Response FIFO:
  - Depth MaxTrans, fall-through.
  - Stores {mem_rdata_i, mem_ruser_i} when mem_rvalid_i is high.
  - Its valid output drives rvalid_o; it pops on rvalid_o & rready_i.
  - rdata_o = the stored wide word's slice at lane-FIFO head × NarrowDataWidth.
  - ruser_o = the stored ruser.
- Outstanding counter:
  - Width $clog2(MaxTrans+1).
  - +1 on accept; −1 on response handshake.
  - Both in the same cycle: counter unchanged.
  - Because it is capped at MaxTrans, the response FIFO and lane FIFO cannot overflow.
- Responses are delivered in order; the wide memory is required to respond in order.
- Simulation assertions:
  - mem_rvalid_i while outstanding == number of responses already buffered → error.
  - Any FIFO overflow → error.

## Timing
- Request latency: 0 cycles, req_i to mem_req_o combinational.
- Response latency:
  - 0 cycles when the response FIFO is empty: mem_rvalid_i → rvalid_o in the same cycle.
  - Otherwise the response waits behind older entries.
- Handshake rules:
  - gnt_o does not depend on req_i; mem_req_o does not depend on mem_gnt_i.
  - While rvalid_o is high and rready_i low, rvalid_o, rdata_o and ruser_o hold stable.
- Reset values:
  - outstanding = 0; both FIFOs empty; rvalid_o = 0.
  - gnt_o = mem_gnt_i (credit available).
  - mem_req_o = req_i.
- Reset mid-operation: all in-flight state is discarded immediately and asynchronously. Responses arriving after reset are illegal; the integration must guarantee the memory is reset together with this block.
- Full credit (outstanding == MaxTrans): gnt_o = 0 and mem_req_o = 0 from that cycle on. A response handshake in cycle t re-enables grant in cycle t+1.

## Test plan
Configuration for all scenarios: Narrow 32, Wide 128, MaxTrans 2.
- Write at 0x1008, wdata 0xDEADBEEF, strb 0xF, mem_gnt_i = 1:
  - Required: mem_addr_o = 0x1000, mem_strb_o = 0x0F00, mem_wdata_o = 0xDEADBEEF×4.
  - mem_rvalid_i one cycle later → rvalid_o in the same cycle.
- Read at 0x1004; mem_rdata_i = 0x44444444_33333333_22222222_11111111, ruser = 1:
  - Required: rdata_o = 0x22222222, ruser_o = 1.
- Two reads accepted with no responses; third req_i:
  - Required: gnt_o = 0, mem_req_o = 0.
  - One response handshake → gnt_o = 1 on the next cycle.
- rready_i = 0 while reads to 0x100C then 0x1000 return on back-to-back cycles:
  - Both responses are buffered.
  - After rready_i = 1: rdata_o = lane 3 word, then lane 0 word, in order.
- outstanding = 1, with accept and response handshake in the same cycle:
  - Required: outstanding stays 1; the lane FIFO pops the old lane and pushes the new one correctly.
- outstanding = 2 with one response buffered; pulse rst_ni low:
  - Required: rvalid_o = 0 and outstanding = 0 immediately.
  - After reset: gnt_o = mem_gnt_i.

Source files
------------

// File: rtl/stream_narrow_to_wide_mem.sv
// rtl/stream_narrow_to_wide_mem.sv - narrow initiator to wide memory word adapter
// Lane-steers narrow requests into a wide word and slices the in-order wide response back down.
module stream_narrow_to_wide_mem #(
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned NarrowDataWidth = 32,
    parameter int unsigned WideDataWidth   = 128,
    parameter int unsigned WUserWidth      = 1,
    parameter int unsigned RUserWidth      = 1,
    parameter int unsigned MaxTrans        = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,

    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [AddrWidth-1:0]         addr_i,
    input  logic [NarrowDataWidth-1:0]   wdata_i,
    input  logic [NarrowDataWidth/8-1:0] strb_i,
    input  logic [WUserWidth-1:0]        wuser_i,
    input  logic                         we_i,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [NarrowDataWidth-1:0]   rdata_o,
    output logic [RUserWidth-1:0]        ruser_o,

    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    output logic [AddrWidth-1:0]         mem_addr_o,
    output logic [WideDataWidth-1:0]     mem_wdata_o,
    output logic [WideDataWidth/8-1:0]   mem_strb_o,
    output logic [WUserWidth-1:0]        mem_wuser_o,
    output logic                         mem_we_o,
    input  logic                         mem_rvalid_i,
    input  logic [WideDataWidth-1:0]     mem_rdata_i,
    input  logic [RUserWidth-1:0]        mem_ruser_i
);

    localparam int unsigned NB     = NarrowDataWidth / 8;
    localparam int unsigned WB     = WideDataWidth / 8;
    localparam int unsigned Lanes  = WB / NB;
    localparam int unsigned OffW   = $clog2(WB);
    localparam int unsigned NbW    = $clog2(NB);
    localparam int unsigned LaneW  = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned CntW   = $clog2(MaxTrans + 1);
    localparam int unsigned PtrW   = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [LaneW-1:0] req_lane;
    logic             credit_ok;
    logic             accept;
    logic             resp_hs;

    logic [CntW-1:0]  outstanding_q, outstanding_d;

    logic [LaneW-1:0] lane_mem_q [MaxTrans];
    logic [PtrW-1:0]  lane_wptr_q, lane_wptr_d;
    logic [PtrW-1:0]  lane_rptr_q, lane_rptr_d;
    logic [LaneW-1:0] lane_head;

    logic [WideDataWidth-1:0] resp_data_q [MaxTrans];
    logic [RUserWidth-1:0]    resp_user_q [MaxTrans];
    logic [PtrW-1:0]          resp_wptr_q, resp_wptr_d;
    logic [PtrW-1:0]          resp_rptr_q, resp_rptr_d;
    logic [CntW-1:0]          resp_cnt_q, resp_cnt_d;
    logic                     resp_empty;
    logic                     resp_push;
    logic                     resp_pop;
    logic [WideDataWidth-1:0] head_data;

    generate
        if (Lanes > 1) begin : g_lane
            assign req_lane = addr_i[OffW-1:NbW];
        end else begin : g_single_lane
            assign req_lane = '0;
        end
    endgenerate

    // Request path: purely combinational steering into the wide word.
    assign mem_addr_o  = {addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign mem_wdata_o = {Lanes{wdata_i}};
    assign mem_strb_o  = WB'(strb_i) << (32'(req_lane) * NB);
    assign mem_we_o    = we_i;
    assign mem_wuser_o = wuser_i;

    assign credit_ok = (outstanding_q < CntW'(MaxTrans));
    assign mem_req_o = req_i & credit_ok;
    assign gnt_o     = mem_gnt_i & credit_ok;
    assign accept    = req_i & gnt_o;
    assign resp_hs   = rvalid_o & rready_i;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !resp_hs) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!accept && resp_hs) begin
            outstanding_d = outstanding_q - CntW'(1);
        end
    end

    // Lane FIFO occupancy always equals outstanding, so it needs no counter of its own.
    always_comb begin
        lane_wptr_d = accept  ? ptr_inc(lane_wptr_q) : lane_wptr_q;
        lane_rptr_d = resp_hs ? ptr_inc(lane_rptr_q) : lane_rptr_q;
    end

    assign lane_head = lane_mem_q[lane_rptr_q];

    // Fall-through response FIFO: an empty FIFO forwards mem_rvalid_i directly.
    assign resp_empty = (resp_cnt_q == '0);
    assign rvalid_o   = !resp_empty | mem_rvalid_i;
    assign resp_push  = mem_rvalid_i & ~(resp_empty & rready_i);
    assign resp_pop   = !resp_empty & rready_i;
    assign head_data  = resp_empty ? mem_rdata_i : resp_data_q[resp_rptr_q];
    assign ruser_o    = resp_empty ? mem_ruser_i : resp_user_q[resp_rptr_q];
    assign rdata_o    = head_data[32'(lane_head) * NarrowDataWidth +: NarrowDataWidth];

    always_comb begin
        resp_wptr_d = resp_push ? ptr_inc(resp_wptr_q) : resp_wptr_q;
        resp_rptr_d = resp_pop  ? ptr_inc(resp_rptr_q) : resp_rptr_q;
        resp_cnt_d  = resp_cnt_q;
        if (resp_push && !resp_pop) begin
            resp_cnt_d = resp_cnt_q + CntW'(1);
        end else if (!resp_push && resp_pop) begin
            resp_cnt_d = resp_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            lane_wptr_q   <= '0;
            lane_rptr_q   <= '0;
            resp_wptr_q   <= '0;
            resp_rptr_q   <= '0;
            resp_cnt_q    <= '0;
            for (int i = 0; i < int'(MaxTrans); i++) begin
                lane_mem_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            lane_wptr_q   <= lane_wptr_d;
            lane_rptr_q   <= lane_rptr_d;
            resp_wptr_q   <= resp_wptr_d;
            resp_rptr_q   <= resp_rptr_d;
            resp_cnt_q    <= resp_cnt_d;
            if (accept) begin
                lane_mem_q[lane_wptr_q] <= req_lane;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (resp_push) begin
            resp_data_q[resp_wptr_q] <= mem_rdata_i;
            resp_user_q[resp_wptr_q] <= mem_ruser_i;
        end
    end

    // A wide response with nothing left to answer means the memory broke ordering or reset rules.
    a_no_unexpected_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && (outstanding_q == resp_cnt_q)));

    a_lane_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(accept && !resp_hs && (outstanding_q == CntW'(MaxTrans))));

    a_resp_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_push && !resp_pop && (resp_cnt_q == CntW'(MaxTrans))));

endmodule
